instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encoder counterpart to the single-cycle CPU's instruction decoder.
- Accepts symbolic instruction descriptors (kind plus register and immediate fields) over a valid/ready handshake.
- Packs each descriptor into a 32-bit MIPS word for the decoder's supported subset, then writes it sequentially into instruction memory through a write port with back-pressure.
- Used by the boot/test infrastructure to load programs into IM before the core is released.

Parameters:
- ADDR_W, 10, word-address width of the instruction memory port.
- DEPTH, 1024, number of words writable; must be at most 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: clear address counter and begin a load session.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid && in_ready.
- in_kind  in  4  0=NOP 1=ADD 2=SUB 3=ORI 4=LUI 5=LW 6=SW 7=BEQ 8=JAL 9=JR; 10-15 illegal.
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  jump target field (JAL).
- mem_we  out  1  write strobe; held until mem_ready.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written this session.
- busy  out  1  session active (RUN state or write pending).
- full  out  1  DEPTH words written; further input is refused.
- err  out  1  sticky: illegal in_kind was received.

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, busy=0, full=0, err=0; FSM enters IDLE.
- FSM states:
  - IDLE: in_ready=0. On start: counter=0, count=0, full=0, err=0, go to RUN.
  - RUN: in_ready = !pending (single output register, no skid). On accept, the encoded word is registered into mem_wdata, mem_addr=counter and mem_we=1 on the next edge, so latency is 1 cycle from accept to mem_we. The write completes on a cycle where mem_we && mem_ready: mem_we drops, counter and count increment, and in_ready returns the following cycle. When count reaches DEPTH after a completed write, go to FULL.
  - FULL: in_ready=0, full=1. Only start or reset leaves FULL; start returns to RUN with a cleared session.
- Throughput: at most one word every 2 cycles. mem_addr and mem_wdata are stable while mem_we=1.
- Encoding (fields are {op, rs, rt, rd, shamt, funct} or {op, rs, rt, imm}):
  - NOP: 32'h0000_0000.
  - ADD: {000000, rs, rt, rd, 00000, 100000}.
  - SUB: same as ADD with funct 100010.
  - ORI: {001101, rs, rt, imm}.
  - LUI: {001111, 00000, rt, imm}; rs is ignored.
  - LW: {100011, rs, rt, imm}.
  - SW: {101011, rs, rt, imm}.
  - BEQ: {000100, rs, rt, imm}.
  - JAL: {000011, target}.
  - JR: {000000, rs, 15'b0, 001000}.
  - Unused fields are forced to 0 regardless of input.
- Illegal kind: the descriptor is accepted and consumed, err is set (sticky), and no write is issued; counter is unchanged.
- start while RUN with a write pending: the pending write is dropped (mem_we=0 next cycle), the counter is cleared, and the FSM stays in RUN. start while RUN with nothing pending: the session restarts.
- start and accept in the same cycle: start wins; the descriptor is not consumed (in_ready is forced 0 that cycle).
- Counter wrap never occurs: FULL blocks input at DEPTH.
- Asynchronous reset at any time, including mid-write: all outputs return immediately to reset values and the FSM goes to IDLE.
- busy = (state==RUN) || mem_we.

Test Plan:
- Reset, start, send ADD rs=1 rt=2 rd=3 with mem_ready=1 -> 1 cycle later mem_we=1, mem_addr=0, mem_wdata=32'h0022_1820; afterwards count=1.
- Sequence ORI rs=0 rt=8 imm=16'h1234, LUI rt=9 imm=16'hABCD with rs=31, JAL target=26'h0000C03, JR rs=31 -> words 32'h3408_1234, 32'h3C09_ABCD, 32'h0C00_0C03, 32'h03E0_0008 at addresses 0..3.
- Hold mem_ready=0 for 5 cycles during a BEQ rs=4 rt=5 imm=16'hFFFE write -> mem_we stays 1, mem_wdata stable at 32'h1085_FFFE, in_ready=0 throughout; write completes when mem_ready rises.
- Send in_kind=12 between two SW descriptors -> err=1; the two SW words land at consecutive addresses 0 and 1; count=2.
- With DEPTH=4, send 5 descriptors -> after the fourth write full=1 and in_ready=0, the fifth is never accepted; a start pulse clears full and count to 0.
- Assert reset while mem_we=1 -> mem_we, count and busy drop to 0 immediately and the FSM is in IDLE; the next start resumes writing at address 0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Purpose: packs symbolic instruction descriptors into MIPS words and streams them into instruction memory.
// Latency: 1 cycle from descriptor accept to mem_we; at most one word every 2 cycles.
// Backpressure: in_ready drops while a write is held for mem_ready; input is refused once DEPTH words are written.
module instr_encoder_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FULL} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              wr_done;
    logic              legal;
    logic [ADDR_W:0]   count_inc;
    logic [31:0]       enc_word;

    // Descriptor packing; fields a kind does not use are forced to zero.
    function automatic logic [31:0] encode(input logic [3:0] kind, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [15:0] imm, input logic [25:0] target);
        logic [31:0] w;
        w = 32'h0000_0000;
        case (kind)
            4'd1: w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
            4'd2: w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
            4'd3: w = {6'b001101, rs, rt, imm};
            4'd4: w = {6'b001111, 5'b00000, rt, imm};
            4'd5: w = {6'b100011, rs, rt, imm};
            4'd6: w = {6'b101011, rs, rt, imm};
            4'd7: w = {6'b000100, rs, rt, imm};
            4'd8: w = {6'b000011, target};
            4'd9: w = {6'b000000, rs, 15'b0, 6'b001000};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    assign legal     = (in_kind <= 4'd9);
    assign enc_word  = encode(in_kind, in_rs, in_rt, in_rd, in_imm, in_target);
    assign wr_done   = mem_we && mem_ready;
    assign count_inc = count + 1'b1;
    assign accept    = in_valid && in_ready;

    // Session state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state and handshake outputs; start overrides everything, including a same-cycle accept.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        full      = 1'b0;
        case (state)
            ST_IDLE: ;
            ST_RUN: begin
                in_ready = !mem_we && !start;
                if (wr_done && (count_inc == DEPTH_C)) state_nxt = ST_FULL;
            end
            ST_FULL: full = 1'b1;
            default: state_nxt = ST_IDLE;
        endcase
        if (start) state_nxt = ST_RUN;
        busy = (state == ST_RUN) || mem_we;
    end

    // Single output register for the memory write, plus session counters and the sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0000_0000;
            count     <= '0;
            err       <= 1'b0;
        end else if (start) begin
            mem_we <= 1'b0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (wr_done) begin
                mem_we <= 1'b0;
                count  <= count_inc;
            end
            if (accept) begin
                if (legal) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= enc_word;
                    mem_addr  <= count[ADDR_W-1:0];
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Purpose: directed bench for instr_encoder_loader with a write scoreboard.
// Latency: expects mem_we one cycle after each accepted legal descriptor.
// Backpressure: drives mem_ready low to hold writes and checks in_ready stays low.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              full;
    logic              err;

    int                checks = 0;
    int                errors = 0;
    wr_t               sb_q[$];
    logic [ADDR_W-1:0] exp_addr = '0;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .busy(busy), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pops and compares a completed write (sampled on the falling edge).
    task automatic mon();
        wr_t e;
        if (mem_we && mem_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", 32'(mem_we), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", mem_wdata, e.data);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        exp_addr = '0;
    endtask

    task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic [31:0] exp_word);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
        in_valid = 1'b1;
        while (!acc && n < 40) begin
            @(negedge clk);
            mon();
            if (in_ready) acc = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
        end else if (k <= 4'd9) begin
            sb_q.push_back('{addr: exp_addr, data: exp_word});
            exp_addr = exp_addr + 1'b1;
            chk("latency_we", 32'(mem_we), 32'd1);
        end else begin
            chk("illegal_no_we", 32'(mem_we), 32'd0);
            chk("illegal_err", 32'(err), 32'd1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 40) begin
            cyc();
            n++;
        end
        chk("drain_left", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
        cyc();
        cyc();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        cyc();
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        // ADD with garbage in unused fields
        pulse_start();
        chk("run_busy", 32'(busy), 32'd1);
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FF_FFFF, 32'h0022_1820);
        drain();
        chk("add_count", 32'(count), 32'd1);

        // Four-word program fills the DEPTH=4 memory
        pulse_start();
        send(4'd3, 5'd0, 5'd8, 5'd7, 16'h1234, 26'h155_5555, 32'h3408_1234);
        send(4'd4, 5'd31, 5'd9, 5'd5, 16'hABCD, 26'h0AA_AAAA, 32'h3C09_ABCD);
        send(4'd8, 5'd3, 5'd3, 5'd3, 16'h0005, 26'h000_0C03, 32'h0C00_0C03);
        send(4'd9, 5'd31, 5'd7, 5'd7, 16'h0055, 26'h3FF_FFFF, 32'h03E0_0008);
        drain();
        cyc();
        chk("full_count", 32'(count), 32'd4);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd0);
        in_kind = 4'd1; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("full_refuse_rdy", 32'(in_ready), 32'd0);
            chk("full_refuse_we", 32'(mem_we), 32'd0);
        end
        in_valid = 1'b0;
        pulse_start();
        chk("restart_full", 32'(full), 32'd0);
        chk("restart_count", 32'(count), 32'd0);

        // BEQ held by mem_ready=0
        mem_ready = 1'b0;
        send(4'd7, 5'd4, 5'd5, 5'd9, 16'hFFFE, 26'h000_1234, 32'h1085_FFFE);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_we", 32'(mem_we), 32'd1);
            chk("stall_wdata", mem_wdata, 32'h1085_FFFE);
            chk("stall_addr", 32'(mem_addr), 32'd0);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        mem_ready = 1'b1;
        drain();
        chk("stall_count", 32'(count), 32'd1);

        // Illegal kind between two SWs
        pulse_start();
        send(4'd6, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 32'hAFA8_0004);
        send(4'd12, 5'd1, 5'd1, 5'd1, 16'h1111, 26'h0, 32'h0);
        send(4'd6, 5'd29, 5'd9, 5'd0, 16'h0008, 26'h0, 32'hAFA9_0008);
        drain();
        chk("illegal_count", 32'(count), 32'd2);
        chk("illegal_sticky", 32'(err), 32'd1);

        // start drops a pending write
        mem_ready = 1'b0;
        send(4'd5, 5'd2, 5'd3, 5'd0, 16'h0010, 26'h0, 32'h8C43_0010);
        pulse_start();
        sb_q.delete();
        chk("drop_we", 32'(mem_we), 32'd0);
        chk("drop_count", 32'(count), 32'd0);
        chk("drop_err", 32'(err), 32'd0);
        chk("drop_busy", 32'(busy), 32'd1);

        // Asynchronous reset mid-write
        send(4'd5, 5'd2, 5'd3, 5'd0, 16'h0010, 26'h0, 32'h8C43_0010);
        #2;
        reset = 1'b1;
        #1;
        sb_q.delete();
        chk("arst_we", 32'(mem_we), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        cyc();
        reset = 1'b0;
        mem_ready = 1'b1;
        cyc();
        chk("arst_idle_rdy", 32'(in_ready), 32'd0);
        pulse_start();
        send(4'd3, 5'd0, 5'd8, 5'd0, 16'h1234, 26'h0, 32'h3408_1234);
        drain();
        chk("resume_count", 32'(count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
